// File: rtl/bb8051_sfr_hub.sv
// bb8051_sfr_hub: SFR bus hub routing 8051 byte/bit SFR accesses to N peripheral slots.
// Core side : req, we, bit_op, addr, wdata, bit_val in; rdata, rbit, ack, err out.
// Slot side : slot_sel (one-hot), slot_we, slot_wdata out; slot_rdata, slot_rdy in.
// Clocking  : clk rising edge; rst is asynchronous and active-low.
module bb8051_sfr_hub #(
    parameter int                   N_SLOTS   = 8,
    parameter logic [N_SLOTS*8-1:0] SLOT_ADDR = 64'h8880_81D0_8382_F0E0,
    parameter int                   TIMEOUT   = 16,
    parameter int                   TO_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic                 bit_op,
    input  logic [7:0]           addr,
    input  logic [7:0]           wdata,
    input  logic                 bit_val,
    output logic [7:0]           rdata,
    output logic                 rbit,
    output logic                 ack,
    output logic                 err,
    output logic [N_SLOTS-1:0]   slot_sel,
    output logic                 slot_we,
    output logic [7:0]           slot_wdata,
    input  logic [N_SLOTS*8-1:0] slot_rdata,
    input  logic [N_SLOTS-1:0]   slot_rdy
);
    localparam int IW = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
    typedef enum logic [2:0] {IDLE, RD, WR, WB, DONE} state_t;
    state_t          r_state, w_next;
    logic [IW-1:0]   r_idx, w_idx;
    logic            w_hit;
    logic [7:0]      w_baddr;
    logic            r_we, r_bit, r_bval, r_err, r_rbit;
    logic [2:0]      r_bidx;
    logic [7:0]      r_wdata, r_rdata;
    logic [TO_W-1:0] r_timer;
    logic            w_rdy, w_tmo, w_busy;
    logic [7:0]      w_d, w_merged;
    // Bit addresses fold onto their byte; lowest matching slot index wins.
    always_comb begin
        w_baddr = bit_op ? {addr[7:3], 3'b000} : addr;
        w_hit   = 1'b0;
        w_idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--)
            if (SLOT_ADDR[8*i +: 8] == w_baddr) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
        if (bit_op && !addr[7]) w_hit = 1'b0;
    end
    assign w_rdy  = slot_rdy[r_idx];
    assign w_d    = slot_rdata[{r_idx, 3'b000} +: 8];
    assign w_tmo  = r_timer == TO_W'(TIMEOUT - 1);
    assign w_busy = r_state inside {RD, WR, WB};
    always_comb begin
        w_merged          = w_d;
        w_merged[r_bidx]  = r_bval;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req) w_next = !w_hit ? DONE : (!we || bit_op) ? RD : WR;
            RD:      if (w_rdy) w_next = r_we ? WB : DONE;
                     else if (w_tmo) w_next = DONE;
            WR, WB:  if (w_rdy || w_tmo) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_bit   <= 1'b0;
            r_bval  <= 1'b0;
            r_bidx  <= '0;
            r_err   <= 1'b0;
            r_rbit  <= 1'b0;
            r_rdata <= '0;
            r_wdata <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            // Timer restarts on every phase entry so each phase gets its own budget.
            r_timer <= (w_next != r_state || r_state == IDLE) ? '0 : r_timer + 1'b1;
            if (r_state == IDLE && req) begin
                r_we   <= we;
                r_bit  <= bit_op;
                r_bidx <= addr[2:0];
                r_bval <= bit_val;
                r_idx  <= w_idx;
                r_err  <= !w_hit;
                if (we && !bit_op) r_wdata <= wdata;
                if (!w_hit) begin
                    r_rdata <= '0;
                    r_rbit  <= 1'b0;
                end
            end
            // Leaving a busy phase without rdy can only be a timeout.
            if (w_busy) r_err <= !w_rdy;
            if (r_state == RD && w_rdy) begin
                if (r_we) r_wdata <= w_merged;
                else begin
                    r_rdata <= w_d;
                    r_rbit  <= r_bit ? w_d[r_bidx] : w_d[0];
                end
            end
        end
    end
    assign slot_sel   = w_busy ? (N_SLOTS'(1) << r_idx) : '0;
    assign slot_we    = r_state inside {WR, WB};
    assign slot_wdata = r_wdata;
    assign ack        = r_state == DONE;
    assign err        = ack && r_err;
    assign rdata      = r_rdata;
    assign rbit       = r_rbit;
endmodule

// File: tb/tb_bb8051_sfr_hub.sv
// tb_bb8051_sfr_hub: randomized transaction bench with a slot responder and an access-level model.
module tb_bb8051_sfr_hub;
    localparam int N  = 8;
    localparam int TO = 16;
    logic clk = 1'b0, rst = 1'b0, req = 1'b0, we = 1'b0, bit_op = 1'b0, bit_val = 1'b0;
    logic [7:0] addr = '0, wdata = '0, rdata, slot_wdata;
    logic rbit, ack, err, slot_we;
    logic [N-1:0] slot_sel, slot_rdy = '0;
    logic [N*8-1:0] slot_rdata;
    logic [7:0] mem [N];
    logic [7:0] sa [N] = '{8'hE0, 8'hF0, 8'h82, 8'h83, 8'hD0, 8'h81, 8'h80, 8'h88};
    int dl [10] = '{0, 0, 0, 1, 2, 4, 14, 15, 16, 25};
    int ncmp = 0, nfail = 0, cyc = 0, pc = 0, nwr = 0, d_rd = 0, d_wr = 0;
    int E = 0, T = 1, W = 1, last_k = 0, k = 0, n0 = 0;
    logic m_on = 1'b0, skip = 1'b0, merr = 1'b0, erb = 1'b0, last_err = 1'b0, pwe = 1'b0;
    logic [7:0] erd = '0, ewd = '0;
    logic [N-1:0] msel = '0, psel = '0;
    logic pk_req = 1'b0;
    int pk_i = 0;
    logic [7:0] pk_v = '0;
    logic [7:0] ra, rs;
    logic rb;

    always #5 clk = ~clk;

    bb8051_sfr_hub dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .bit_op(bit_op), .addr(addr),
        .wdata(wdata), .bit_val(bit_val), .rdata(rdata), .rbit(rbit), .ack(ack), .err(err),
        .slot_sel(slot_sel), .slot_we(slot_we), .slot_wdata(slot_wdata),
        .slot_rdata(slot_rdata), .slot_rdy(slot_rdy)
    );

    for (genvar g = 0; g < N; g++) begin : g_rd
        assign slot_rdata[8*g +: 8] = mem[g];
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    // Peripheral slots: accept a write when selected, write-enabled and ready.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pk_req) mem[pk_i] <= pk_v;
        for (int i = 0; i < N; i++)
            if (slot_sel[i] && slot_we && slot_rdy[i]) begin
                mem[i] <= slot_wdata;
                nwr <= nwr + 1;
            end
    end

    // Selected slot becomes ready after a programmed number of cycles in the current phase.
    always @(negedge clk) begin
        pc = (slot_sel != '0 && slot_sel == psel && slot_we == pwe) ? pc + 1 : 0;
        psel = slot_sel;
        pwe  = slot_we;
        slot_rdy = N'($urandom);
        for (int i = 0; i < N; i++)
            if (slot_sel[i]) slot_rdy[i] = pc >= (slot_we ? d_wr : d_rd);
    end

    // Cycle-by-cycle compare against the access-level expectation.
    always @(negedge clk) begin
        if (!skip) begin
            if (m_on) begin
                k = cyc - E + 1;
                chk("ack", 32'(ack), 32'(k == T));
                chk("err", 32'(err), 32'(k == T && merr));
                chk("slot_sel", 32'(slot_sel), 32'((k < T) ? msel : '0));
                chk("slot_we", 32'(slot_we), 32'(k >= W && k < T));
                if (k >= W && k < T) chk("slot_wdata", 32'(slot_wdata), 32'(ewd));
                if (k == T) begin
                    chk("rdata", 32'(rdata), 32'(erd));
                    chk("rbit", 32'(rbit), 32'(erb));
                end
                if (ack) begin
                    last_k   = k;
                    last_err = err;
                end
            end else begin
                chk("idle_ack", 32'(ack), 0);
                chk("idle_sel", 32'(slot_sel), 0);
                chk("idle_we", 32'(slot_we), 0);
            end
        end
    end

    task automatic poke(input int i, input logic [7:0] v);
        pk_i = i;
        pk_v = v;
        pk_req = 1'b1;
        @(posedge clk);
        #1;
        pk_req = 1'b0;
    endtask

    // Issues one access and builds its expected timeline from phase lengths.
    task automatic access(input logic w, input logic b, input logic [7:0] a, input logic [7:0] wd,
                          input logic bv, input int drd, input int dwr);
        logic [7:0] ba, v, nv;
        int s, l1, l2;
        logic ok1, ok2, wr_ok;
        ba = b ? {a[7:3], 3'b000} : a;
        s = -1;
        for (int i = N - 1; i >= 0; i--) if (sa[i] == ba) s = i;
        if (b && a < 8'h80) s = -1;
        d_rd = drd;
        d_wr = dwr;
        ok1 = drd < TO;
        ok2 = dwr < TO;
        l1 = (ok1 ? drd : TO - 1) + 1;
        l2 = (ok2 ? dwr : TO - 1) + 1;
        v = '0;
        nv = '0;
        wr_ok = 1'b0;
        if (s < 0) begin
            T = 1; W = 1; merr = 1'b1; msel = '0; erd = '0; erb = 1'b0;
        end else begin
            v = mem[s];
            msel = N'(1) << s;
            nv = v;
            nv[a[2:0]] = bv;
            if (!w) begin
                T = l1 + 1; W = T; merr = !ok1;
                if (ok1) begin
                    erd = v;
                    erb = b ? v[a[2:0]] : v[0];
                end
            end else if (!b) begin
                T = l2 + 1; W = 1; merr = !ok2; ewd = wd; wr_ok = ok2;
            end else if (!ok1) begin
                T = l1 + 1; W = T; merr = 1'b1;
            end else begin
                W = l1 + 1; T = l1 + l2 + 1; merr = !ok2; ewd = nv; wr_ok = ok2;
            end
        end
        n0 = nwr;
        req = 1'b1; we = w; bit_op = b; addr = a; wdata = wd; bit_val = bv;
        @(posedge clk);
        #1;
        E = cyc;
        req = 1'b0;
        m_on = 1'b1;
        repeat (T) @(negedge clk);
        @(posedge clk);
        #1;
        m_on = 1'b0;
        chk("write_count", 32'(nwr - n0), 32'(wr_ok));
        if (s >= 0) chk("slot_value", 32'(mem[s]), 32'(wr_ok ? (b ? nv : wd) : v));
    endtask

    initial begin
        #2;
        chk("rst_sel", 32'(slot_sel), 0);
        chk("rst_we", 32'(slot_we), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_rbit", 32'(rbit), 0);
        chk("rst_wdata", 32'(slot_wdata), 0);
        for (int i = 0; i < N; i++) poke(i, 8'($urandom));
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Hand-computed anchors.
        poke(1, 8'h5A);
        access(1'b0, 1'b0, 8'hF0, 8'h00, 1'b0, 0, 0);
        chk("lit_f0_lat", 32'(last_k), 2);
        chk("lit_f0_rdata", 32'(rdata), 32'h5A);
        chk("lit_f0_err", 32'(last_err), 0);
        poke(0, 8'h00);
        access(1'b1, 1'b1, 8'hE3, 8'h00, 1'b1, 0, 0);
        chk("lit_e3_set", 32'(mem[0]), 32'h08);
        chk("lit_e3_lat", 32'(last_k), 3);
        poke(0, 8'hFF);
        access(1'b1, 1'b1, 8'hE3, 8'h00, 1'b0, 0, 0);
        chk("lit_e3_clr", 32'(mem[0]), 32'hF7);
        poke(4, 8'h80);
        access(1'b0, 1'b1, 8'hD7, 8'h00, 1'b0, 0, 0);
        chk("lit_d7_rbit", 32'(rbit), 1);
        chk("lit_d7_rdata", 32'(rdata), 32'h80);
        access(1'b0, 1'b1, 8'h20, 8'h00, 1'b0, 0, 0);
        chk("lit_20_lat", 32'(last_k), 1);
        chk("lit_20_err", 32'(last_err), 1);
        access(1'b0, 1'b0, 8'h99, 8'h00, 1'b0, 0, 0);
        chk("lit_99_lat", 32'(last_k), 1);
        chk("lit_99_rdata", 32'(rdata), 0);
        access(1'b0, 1'b0, 8'hE0, 8'h00, 1'b0, 100, 0);
        chk("lit_to_lat", 32'(last_k), 17);
        chk("lit_to_err", 32'(last_err), 1);
        access(1'b0, 1'b0, 8'hE0, 8'h00, 1'b0, 4, 0);
        chk("lit_slow_lat", 32'(last_k), 6);
        chk("lit_slow_err", 32'(last_err), 0);
        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    ra = sa[$urandom_range(0, N - 1)];
                    rb = 1'b0;
                end
                1: begin
                    rs = sa[$urandom_range(0, N - 1)];
                    ra = {rs[7:3], 3'($urandom)};
                    rb = 1'b1;
                end
                default: begin
                    ra = 8'($urandom);
                    rb = 1'($urandom);
                end
            endcase
            access(1'($urandom), rb, ra, 8'($urandom), 1'($urandom),
                   dl[$urandom_range(0, 9)], dl[$urandom_range(0, 9)]);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        // Reset asserted while a bit write waits in its write-back phase.
        poke(0, 8'h00);
        skip = 1'b1;
        d_rd = 0;
        d_wr = 100;
        n0 = nwr;
        req = 1'b1; we = 1'b1; bit_op = 1'b1; addr = 8'hE1; bit_val = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("wb_sel", 32'(slot_sel), 1);
        chk("wb_we", 32'(slot_we), 1);
        chk("wb_wdata", 32'(slot_wdata), 32'h02);
        rst = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(slot_sel), 0);
        chk("mid_rst_we", 32'(slot_we), 0);
        chk("mid_rst_ack", 32'(ack), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_rdata", 32'(rdata), 0);
        chk("mid_rst_rbit", 32'(rbit), 0);
        chk("mid_rst_wdata", 32'(slot_wdata), 0);
        @(posedge clk);
        #1;
        chk("mid_rst_nowrite", 32'(nwr - n0), 0);
        rst = 1'b1;
        erd = '0;
        erb = 1'b0;
        @(posedge clk);
        #1;
        skip = 1'b0;
        access(1'b0, 1'b0, 8'hE0, 8'h00, 1'b0, 0, 0);
        chk("post_rst_lat", 32'(last_k), 2);
        chk("post_rst_rdata", 32'(rdata), 0);
        access(1'b1, 1'b0, 8'h81, 8'h3C, 1'b0, 1, 2);
        chk("post_rst_sp", 32'(mem[5]), 32'h3C);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
